// File: rtl/pd_stream_arbiter.sv
// pd_stream_arbiter
//
// Round-robin, packet-locked arbiter. NUM_REQ producers of posit-decoded
// beats share one downstream normaliser/encoder. Once a requester is granted,
// the grant holds from the first beat of its packet through the beat that
// carries eow, so packets never interleave. Each new arbitration costs one
// IDLE cycle.
//
// Beat payload (DATA_W bits, MSB first):
//   {scale[SCALE_W], fraction[FRAC_W], NaR, sign, zero, guard, round, sticky}
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_rts      per-requester ready-to-send
//   s_rtr      per-requester ready-to-receive; only the granted bit can be set
//   s_sow      per-requester start-of-word (first beat of a packet)
//   s_eow      per-requester end-of-word (last beat of a packet)
//   s_data     packed payloads; requester i is at [i*DATA_W +: DATA_W]
//   m_rts      downstream ready-to-send
//   m_rtr      downstream ready-to-receive
//   m_sow      downstream start-of-word
//   m_eow      downstream end-of-word
//   m_data     downstream payload
//   grant_idx  granted requester; meaningful while busy=1
//   busy       1 while a packet is locked
module pd_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SCALE_W = 6,
    parameter int FRAC_W  = 13,
    localparam int DATA_W = SCALE_W + FRAC_W + 6,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        s_rts,
    output logic [NUM_REQ-1:0]        s_rtr,
    input  logic [NUM_REQ-1:0]        s_sow,
    input  logic [NUM_REQ-1:0]        s_eow,
    input  logic [NUM_REQ*DATA_W-1:0] s_data,
    output logic                      m_rts,
    input  logic                      m_rtr,
    output logic                      m_sow,
    output logic                      m_eow,
    output logic [DATA_W-1:0]         m_data,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   r_last_idx;

    state_t             w_next_state;
    logic [IDX_W-1:0]   w_next_grant;
    logic [IDX_W-1:0]   w_next_last;
    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_pick;
    logic               w_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= '0;
            r_last_idx  <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state     <= w_next_state;
            r_grant_idx <= w_next_grant;
            r_last_idx  <= w_next_last;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant_idx;
        w_next_last  = r_last_idx;
        w_cand       = '0;
        w_pick       = '0;
        w_found      = 1'b0;
        s_rtr        = '0;
        m_rts        = 1'b0;
        m_sow        = 1'b0;
        m_eow        = 1'b0;
        m_data       = '0;

        case (r_state)
            ST_IDLE: begin
                // Search starts one past the last packet's owner, so the
                // previous winner has the lowest priority this round.
                for (int k = 1; k <= NUM_REQ; k++) begin
                    w_cand = IDX_W'((int'(r_last_idx) + k) % NUM_REQ);
                    if (!w_found && s_rts[w_cand]) begin
                        w_found = 1'b1;
                        w_pick  = w_cand;
                    end
                end
                if (w_found) begin
                    w_next_state = ST_LOCKED;
                    w_next_grant = w_pick;
                end
            end

            ST_LOCKED: begin
                m_rts              = s_rts[r_grant_idx];
                m_sow              = s_sow[r_grant_idx];
                m_eow              = s_eow[r_grant_idx];
                m_data             = s_data[r_grant_idx*DATA_W +: DATA_W];
                s_rtr[r_grant_idx] = m_rtr;
                // Release only on the eow beat actually transferring; a
                // stalled eow beat keeps the lock.
                if (s_rts[r_grant_idx] && m_rtr && s_eow[r_grant_idx]) begin
                    w_next_state = ST_IDLE;
                    w_next_last  = r_grant_idx;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign grant_idx = r_grant_idx;
    assign busy      = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_pd_stream_arbiter.sv
module tb_pd_stream_arbiter;

    localparam int NUM_REQ = 4;
    localparam int SCALE_W = 6;
    localparam int FRAC_W  = 13;
    localparam int DATA_W  = SCALE_W + FRAC_W + 6;
    localparam int IDX_W   = $clog2(NUM_REQ);

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        s_rts;
    logic [NUM_REQ-1:0]        s_rtr;
    logic [NUM_REQ-1:0]        s_sow;
    logic [NUM_REQ-1:0]        s_eow;
    logic [NUM_REQ*DATA_W-1:0] s_data;
    logic                      m_rts;
    logic                      m_rtr;
    logic                      m_sow;
    logic                      m_eow;
    logic [DATA_W-1:0]         m_data;
    logic [IDX_W-1:0]          grant_idx;
    logic                      busy;

    always #5 clk = ~clk;

    pd_stream_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SCALE_W (SCALE_W),
        .FRAC_W  (FRAC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_rts     (s_rts),
        .s_rtr     (s_rtr),
        .s_sow     (s_sow),
        .s_eow     (s_eow),
        .s_data    (s_data),
        .m_rts     (m_rts),
        .m_rtr     (m_rtr),
        .m_sow     (m_sow),
        .m_eow     (m_eow),
        .m_data    (m_data),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              sow;
        logic              eow;
    } beat_t;

    // src_q: what each producer still has to send; exp_q: scoreboard of
    // beats expected to appear downstream, per requester, in order.
    beat_t src_q[NUM_REQ][$];
    beat_t exp_q[NUM_REQ][$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [NUM_REQ-1:0] xfer_flag = '0;
    int  gap_pct = 0;
    int  rtr_pct = 100;
    bit  rtr_pat = 1'b0;
    int  pat_cnt = 0;

    // Reference model state: who owns the output, and who owned it last.
    bit  mdl_busy = 1'b0;
    int  mdl_g    = 0;
    int  mdl_last = NUM_REQ - 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the model and scoreboard.
    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_rtr;
        beat_t              b;
        int                 idx;
        bit                 found;
        xfer_flag = s_rts & s_rtr;
        if (!rst_n) begin
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_m_rts", 64'(m_rts), 64'd0);
            check("rst_s_rtr", 64'(s_rtr), 64'd0);
            check("rst_m_sow_eow", 64'({m_sow, m_eow}), 64'd0);
            check("rst_m_data", 64'(m_data), 64'd0);
            check("rst_grant_idx", 64'(grant_idx), 64'd0);
            mdl_busy = 1'b0;
            mdl_g    = 0;
            mdl_last = NUM_REQ - 1;
        end else begin
            check("busy", 64'(busy), 64'(mdl_busy));
            if (!mdl_busy) begin
                check("idle_m_rts", 64'(m_rts), 64'd0);
                check("idle_s_rtr", 64'(s_rtr), 64'd0);
            end else begin
                exp_rtr        = '0;
                exp_rtr[mdl_g] = m_rtr;
                check("grant_idx", 64'(grant_idx), 64'(mdl_g));
                check("m_rts", 64'(m_rts), 64'(s_rts[mdl_g]));
                check("s_rtr", 64'(s_rtr), 64'(exp_rtr));
                if (s_rts[mdl_g]) begin
                    if (exp_q[mdl_g].size() == 0) begin
                        check("unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        b = exp_q[mdl_g][0];
                        check("beat_payload", 64'({m_data, m_sow, m_eow}), 64'({b.d, b.sow, b.eow}));
                        if (m_rtr) void'(exp_q[mdl_g].pop_front());
                    end
                end
            end
            // Advance the model by one clock.
            if (!mdl_busy) begin
                found = 1'b0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (mdl_last + k) % NUM_REQ;
                    if (!found && s_rts[idx]) begin
                        found = 1'b1;
                        mdl_g = idx;
                    end
                end
                if (found) mdl_busy = 1'b1;
            end else if (s_rts[mdl_g] && m_rtr && s_eow[mdl_g]) begin
                mdl_busy = 1'b0;
                mdl_last = mdl_g;
            end
        end
    end

    task automatic add_pkt(input int i, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d   = DATA_W'({$urandom, $urandom});
            b.sow = (k == 0);
            b.eow = (k == len - 1);
            src_q[i].push_back(b);
            exp_q[i].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        beat_t b;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                s_rts[i] = ($urandom_range(99) >= gap_pct);
                s_sow[i] = b.sow;
                s_eow[i] = b.eow;
                s_data[i*DATA_W +: DATA_W] = b.d;
            end else begin
                s_rts[i] = 1'b0;
                s_sow[i] = 1'b0;
                s_eow[i] = 1'b0;
                s_data[i*DATA_W +: DATA_W] = '0;
            end
        end
        if (rtr_pat) begin
            m_rtr = (pat_cnt % 3 == 0);
            pat_cnt++;
        end else begin
            m_rtr = ($urandom_range(99) < rtr_pct);
        end
    endtask

    task automatic cycle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++)
                if (xfer_flag[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            drive_inputs();
        end
    endtask

    task automatic flush_all();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        s_rts  = '0;
        s_sow  = '0;
        s_eow  = '0;
        s_data = '0;
    endtask

    initial begin
        int budget;
        bit pending;
        rst_n  = 1'b0;
        s_rts  = '0;
        s_sow  = '0;
        s_eow  = '0;
        s_data = '0;
        m_rtr  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single 3-beat packet on req2.
        gap_pct = 0; rtr_pct = 100;
        add_pkt(2, 3);
        cycle(8);

        // All four requesters with single-beat packets: round-robin order.
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NUM_REQ; i++) add_pkt(i, 1);
        cycle(30);

        // req0 arrives while req1's 4-beat packet is in flight.
        add_pkt(1, 4);
        cycle(2);
        add_pkt(0, 1);
        cycle(12);

        // Downstream backpressure pattern 1,0,0,1,0,0...
        rtr_pat = 1'b1; pat_cnt = 0;
        add_pkt(2, 5);
        cycle(24);
        rtr_pat = 1'b0;

        // Reset on the 2nd beat of a 3-beat req3 packet.
        add_pkt(3, 3);
        budget = 0;
        while (src_q[3].size() != 2 && budget < 20) begin
            cycle(1);
            budget++;
        end
        check("reach_beat2", 64'(src_q[3].size()), 64'd2);
        rst_n = 1'b0;
        flush_all();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        add_pkt(0, 1);
        add_pkt(3, 1);
        cycle(10);

        // Two back-to-back single-beat packets from req2 alone.
        add_pkt(2, 1);
        add_pkt(2, 1);
        cycle(10);

        // Randomised traffic with source gaps and downstream stalls.
        gap_pct = 20; rtr_pct = 70;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(3) == 0)
                add_pkt(int'($urandom_range(NUM_REQ - 1)), int'($urandom_range(4, 1)));
            cycle(1);
        end

        // Drain everything still outstanding, bounded.
        gap_pct = 0; rtr_pct = 100;
        budget  = 0;
        pending = 1'b1;
        while (pending && budget < 2000) begin
            cycle(1);
            budget++;
            pending = 1'b0;
            for (int i = 0; i < NUM_REQ; i++)
                if (exp_q[i].size() != 0 || src_q[i].size() != 0) pending = 1'b1;
        end
        cycle(3);
        for (int i = 0; i < NUM_REQ; i++)
            check("drain_empty", 64'(exp_q[i].size()), 64'd0);
        check("final_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
